lcd_reader: RTL and testbench

LCD_READER -- requirements
Module: lcd_reader

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_bus_timer.sv | 38 +++
 rtl/lcd_reader.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style LCD read path:
//   - lcd_state_t      : read-cycle FSM state encoding
//   - LCD_*_DEF        : default bus timing constants (in iCLK cycles)
//   - LCD_BUSY_BIT,
//     LCD_ADDR_MSB/LSB : bit positions inside a status byte
//   - status_busy(),
//     status_addr()    : helpers that split a status byte into its fields
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } lcd_state_t;

    localparam int          LCD_CLK_DIVIDE_DEF = 16;
    localparam int          LCD_SETUP_CYC_DEF  = 4;
    localparam int          LCD_HOLD_CYC_DEF   = 4;
    localparam logic [17:0] LCD_POLL_MAX_DEF   = 18'h3FFFE;

    localparam int LCD_CNT_W = 18;   // busy-poll read counter width
    localparam int LCD_TMR_W = 16;   // bus phase timer width

    localparam int LCD_BUSY_BIT = 7;
    localparam int LCD_ADDR_MSB = 6;
    localparam int LCD_ADDR_LSB = 0;

    function automatic logic status_busy(input logic [7:0] status);
        return status[LCD_BUSY_BIT];
    endfunction

    function automatic logic [LCD_ADDR_MSB-LCD_ADDR_LSB:0] status_addr(input logic [7:0] status);
        return status[LCD_ADDR_MSB:LCD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// -----------------------------------------------------------------------------
// lcd_bus_timer
// Loadable down-counter with zero flag, used to time the SETUP, STROBE and
// HOLD phases of an LCD read cycle. Loading N-1 makes zero assert on the
// N-th cycle after the load edge.
//   iCLK     : clock (rising edge)
//   iRST_N   : asynchronous active-low reset
//   load     : load load_val on the next edge (has priority over counting)
//   load_val : value to load
//   zero     : counter is at zero (counting stops there)
// -----------------------------------------------------------------------------
module lcd_bus_timer
    import lcd_pkg::*;
#(
    parameter int W = LCD_TMR_W
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// -----------------------------------------------------------------------------
// lcd_reader
// Read-only LCD bus engine. One iStart (accepted in IDLE) performs a single
// read cycle: SETUP (RS/RW valid, EN low) -> STROBE (EN high) -> SAMPLE (EN
// still high, bus captured) -> HOLD (EN low) -> DONE (oDone pulse).
// With poll mode built in, a status read with iPOLL set repeats the read
// while the busy flag is set, up to POLL_MAX extra reads, and flags oTIMEOUT
// if it gave up with the flag still set.
//
// Build option: define LCD_READ_POLL_EN to include poll mode, the 18-bit read
// counter and oTIMEOUT. Without it iPOLL is ignored and oTIMEOUT is 0.
//
// Ports:
//   iCLK, iRST_N   : clock, asynchronous active-low reset
//   iStart         : request pulse (ignored outside IDLE)
//   iRS            : 0 = status read, 1 = DDRAM/CGRAM data read
//   iPOLL          : with iRS=0, repeat reads until busy clears
//   oDATA          : last byte sampled from the bus
//   oBUSY          : busy bit of last status read, 0 after a data read
//   oDone          : one-cycle completion pulse
//   oTIMEOUT       : one-cycle pulse with oDone when polling gave up
//   LCD_DATA_I     : LCD data bus input
//   LCD_DATA_OE    : bus drive enable (always 0)
//   LCD_RW         : read/write select (always 1)
//   LCD_EN         : enable strobe
//   LCD_RS         : register select, latched at acceptance
// -----------------------------------------------------------------------------
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int          CLK_DIVIDE = LCD_CLK_DIVIDE_DEF,
    parameter int          SETUP_CYC  = LCD_SETUP_CYC_DEF,
    parameter int          HOLD_CYC   = LCD_HOLD_CYC_DEF,
    parameter logic [17:0] POLL_MAX   = LCD_POLL_MAX_DEF
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPOLL,
    output logic [7:0] oDATA,
    output logic       oBUSY,
    output logic       oDone,
    output logic       oTIMEOUT,
    input  logic [7:0] LCD_DATA_I,
    output logic       LCD_DATA_OE,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    // Timer reload values: the phase lasts (value + 1) cycles.
    localparam logic [LCD_TMR_W-1:0] SETUP_LD  = LCD_TMR_W'(SETUP_CYC - 1);
    localparam logic [LCD_TMR_W-1:0] STROBE_LD = LCD_TMR_W'(CLK_DIVIDE - 1);
    localparam logic [LCD_TMR_W-1:0] HOLD_LD   = LCD_TMR_W'(HOLD_CYC - 1);

    lcd_state_t           state_q;
    lcd_state_t           state_d;
    logic                 tmr_load;
    logic [LCD_TMR_W-1:0] tmr_val;
    logic                 tmr_zero;
    logic                 rs_q;
    logic                 accept;
    logic                 repeat_read;

    assign accept = (state_q == ST_IDLE) && iStart;

`ifdef LCD_READ_POLL_EN
    logic                 poll_q;
    logic [LCD_CNT_W-1:0] rd_cnt;
    logic                 timeout_hit;

    // oBUSY holds the busy bit of the read just finished; poll_q is only
    // ever set for status reads, so it is the live busy flag here.
    assign repeat_read = poll_q && oBUSY && (rd_cnt < POLL_MAX);
    assign timeout_hit = poll_q && oBUSY && (rd_cnt == POLL_MAX);
`else
    logic                 unused_poll;
    localparam logic [17:0] poll_max_unused = POLL_MAX;

    assign unused_poll = iPOLL;
    assign repeat_read = 1'b0;
`endif

    lcd_bus_timer #(
        .W (LCD_TMR_W)
    ) u_timer (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    // Timer loads are issued on the transition into each timed phase.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d  = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                state_d  = ST_HOLD;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end
            ST_HOLD: begin
                if (tmr_zero) begin
                    if (repeat_read) begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        LCD_EN   = 1'b0;
        oDone    = 1'b0;
        oTIMEOUT = 1'b0;
        case (state_q)
            ST_STROBE, ST_SAMPLE: begin
                LCD_EN = 1'b1;
            end
            ST_DONE: begin
                oDone = 1'b1;
`ifdef LCD_READ_POLL_EN
                oTIMEOUT = timeout_hit;
`endif
            end
            default: begin
                LCD_EN = 1'b0;
            end
        endcase
    end

    assign LCD_RW      = 1'b1;
    assign LCD_DATA_OE = 1'b0;
    assign LCD_RS      = rs_q;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rs_q  <= 1'b0;
            oDATA <= '0;
            oBUSY <= 1'b0;
`ifdef LCD_READ_POLL_EN
            poll_q <= 1'b0;
            rd_cnt <= '0;
`endif
        end else begin
            if (accept) begin
                rs_q <= iRS;
`ifdef LCD_READ_POLL_EN
                poll_q <= iPOLL & ~iRS;
                rd_cnt <= '0;
`endif
            end
            if (state_q == ST_SAMPLE) begin
                oDATA <= LCD_DATA_I;
                oBUSY <= rs_q ? 1'b0 : status_busy(LCD_DATA_I);
            end
`ifdef LCD_READ_POLL_EN
            if ((state_q == ST_HOLD) && tmr_zero && repeat_read) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
`timescale 1ns/1ps
module tb_lcd_reader;

    // Bus timing as seen from the pins (defaults of the design).
    localparam int T_SETUP  = 4;
    localparam int T_STROBE = 16;
    localparam int T_HOLD   = 4;
    localparam int RD_CYC   = T_SETUP + T_STROBE + 1 + T_HOLD;  // 25 per read
    localparam int EN_CYC   = T_STROBE + 1;                     // 17 per read
    localparam int TB_PMAX  = 4;

`ifdef LCD_READ_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rs = 1'b0;
    logic       poll = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic [7:0] o_data;
    logic       o_busy, o_done, o_to, oe, rw, en, lrs;

    lcd_reader #(
        .POLL_MAX (18'(TB_PMAX))
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iStart      (start),
        .iRS         (rs),
        .iPOLL       (poll),
        .oDATA       (o_data),
        .oBUSY       (o_busy),
        .oDone       (o_done),
        .oTIMEOUT    (o_to),
        .LCD_DATA_I  (data_i),
        .LCD_DATA_OE (oe),
        .LCD_RW      (rw),
        .LCD_EN      (en),
        .LCD_RS      (lrs)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         rs;
        bit         poll;
        int         nbusy;      // reads returning bval before fval appears
        logic [7:0] bval;
        logic [7:0] fval;
        bit         spam;       // extra iStart pulses during SETUP/HOLD
        int         exp_reads;
        logic [7:0] exp_data;
        bit         exp_busy;
        bit         exp_to;
    } vec_t;

    typedef logic [7:0] resp_t [8];

    function automatic resp_t mk_resp(input int nbusy, input logic [7:0] bval, input logic [7:0] fval);
        resp_t r;
        for (int i = 0; i < 8; i++) r[i] = (i < nbusy) ? bval : fval;
        return r;
    endfunction

    // Reference: a transaction is a sequence of reads; in poll mode it keeps
    // reading while the busy bit is set, allowing TB_PMAX retries.
    function automatic void model(input bit m_rs, input bit m_poll, input resp_t r,
                                  output int reads, output logic [7:0] d,
                                  output bit b, output bit to);
        bit polling;
        polling = POLL_EN && m_poll && !m_rs;
        reads = 0;
        to    = 1'b0;
        d     = 8'h00;
        while (reads < 16) begin
            d = r[(reads > 7) ? 7 : reads];
            reads++;
            if (!(polling && d[7])) break;
            if (reads - 1 >= TB_PMAX) begin
                to = 1'b1;
                break;
            end
        end
        b = m_rs ? 1'b0 : d[7];
    endfunction

    task automatic run_txn(input string tag, input bit t_rs, input bit t_poll, input resp_t r,
                           input bit spam, input int exp_reads, input logic [7:0] exp_data,
                           input bit exp_busy, input bit exp_to);
        int pulses = 0, en_cyc = 0, done_cnt = 0, done_cyc = -1;
        int viol = 0, stray_to = 0, exp_done;
        logic prev_en = 1'b0;
        logic to_at_done = 1'b0, busy_at_done = 1'b0;
        logic [7:0] data_at_done = 8'h00;
        exp_done = exp_reads * RD_CYC + 1;
        @(negedge clk);
        data_i = r[0];
        rs     = t_rs;
        poll   = t_poll;
        start  = 1'b1;
        for (int cyc = 1; cyc <= exp_done + 40; cyc++) begin
            @(negedge clk);
            start = spam && (cyc < exp_done - 1) &&
                    (((cyc % RD_CYC) == 2) || ((cyc % RD_CYC) == 23));
            rs   = 1'($urandom_range(0, 1));
            poll = 1'($urandom_range(0, 1));
            if (en && !prev_en) begin
                pulses++;
                data_i = r[(pulses - 1 > 7) ? 7 : pulses - 1];
            end
            if (!en) data_i = 8'($urandom);
            if (en) en_cyc++;
            prev_en = en;
            if (rw !== 1'b1 || oe !== 1'b0 || lrs !== t_rs) viol++;
            if (o_to && !o_done) stray_to++;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    to_at_done   = o_to;
                    data_at_done = o_data;
                    busy_at_done = o_busy;
                end
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;
        chk({tag, " done_count"},   32'(done_cnt), 32'd1);
        chk({tag, " done_latency"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, " en_pulses"},    32'(pulses),   32'(exp_reads));
        chk({tag, " en_cycles"},    32'(en_cyc),   32'(exp_reads * EN_CYC));
        chk({tag, " data"},         32'(data_at_done), 32'(exp_data));
        chk({tag, " busy"},         32'(busy_at_done), 32'(exp_busy));
        chk({tag, " timeout"},      32'(to_at_done),   32'(exp_to));
        chk({tag, " bus_pins"},     32'(viol),     32'd0);
        chk({tag, " stray_timeout"}, 32'(stray_to), 32'd0);
        chk({tag, " idle_data_hold"}, 32'(o_data), 32'(exp_data));
    endtask

    vec_t vecs[8];

    initial begin
        int         n_rd;
        logic [7:0] m_d;
        bit         m_b, m_to;
        resp_t      r;
        int         early_done;

        // rs, poll, nbusy, bval, fval, spam, reads, data, busy, timeout
        vecs[0] = '{1'b0, 1'b0, 8, 8'h85, 8'h85, 1'b0, 1, 8'h85, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8, 8'h41, 8'h41, 1'b0, 1, 8'h41, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8, 8'h80, 8'h80, 1'b0, 1, 8'h80, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 0, 8'hC0, 8'h3A, 1'b1, 1, 8'h3A, 1'b0, 1'b0};
        if (POLL_EN) begin
            vecs[4] = '{1'b0, 1'b1, 3, 8'h80, 8'h05, 1'b0, 4, 8'h05, 1'b0, 1'b0};
            vecs[5] = '{1'b0, 1'b1, 8, 8'hFF, 8'hFF, 1'b0, 5, 8'hFF, 1'b1, 1'b1};
            vecs[6] = '{1'b0, 1'b1, 4, 8'h9A, 8'h00, 1'b1, 5, 8'h00, 1'b0, 1'b0};
            vecs[7] = '{1'b0, 1'b1, 2, 8'hFF, 8'h7F, 1'b0, 3, 8'h7F, 1'b0, 1'b0};
        end else begin
            vecs[4] = '{1'b0, 1'b1, 3, 8'h80, 8'h05, 1'b0, 1, 8'h80, 1'b1, 1'b0};
            vecs[5] = '{1'b0, 1'b1, 8, 8'hFF, 8'hFF, 1'b0, 1, 8'hFF, 1'b1, 1'b0};
            vecs[6] = '{1'b0, 1'b1, 4, 8'h9A, 8'h00, 1'b1, 1, 8'h9A, 1'b1, 1'b0};
            vecs[7] = '{1'b0, 1'b1, 2, 8'hFF, 8'h7F, 1'b0, 1, 8'hFF, 1'b1, 1'b0};
        end

        // Reset state while iRST_N is low.
        #12;
        chk("rst_en",      32'(en),     32'd0);
        chk("rst_rw",      32'(rw),     32'd1);
        chk("rst_rs",      32'(lrs),    32'd0);
        chk("rst_oe",      32'(oe),     32'd0);
        chk("rst_data",    32'(o_data), 32'd0);
        chk("rst_busy",    32'(o_busy), 32'd0);
        chk("rst_done",    32'(o_done), 32'd0);
        chk("rst_timeout", 32'(o_to),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            r = mk_resp(vecs[i].nbusy, vecs[i].bval, vecs[i].fval);
            run_txn($sformatf("vec%0d", i), vecs[i].rs, vecs[i].poll, r, vecs[i].spam,
                    vecs[i].exp_reads, vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_to);
        end

        // Reset during STROBE aborts at once with no completion.
        @(negedge clk);
        rs = 1'b1; poll = 1'b0; data_i = 8'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);          // cycle 8: inside STROBE
        chk("abort_en_before", 32'(en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_en_now",   32'(en),     32'd0);
        chk("abort_rs_clear", 32'(lrs),    32'd0);
        chk("abort_data_clr", 32'(o_data), 32'd0);
        early_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done) early_done++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (o_done || en) early_done++;
        end
        chk("abort_no_done", 32'(early_done), 32'd0);
        r = mk_resp(8, 8'h85, 8'h85);
        run_txn("after_abort", 1'b0, 1'b0, r, 1'b1, 1, 8'h85, 1'b1, 1'b0);

        // Randomised transactions against the reference.
        for (int k = 0; k < 12; k++) begin
            bit         t_rs, t_poll, t_spam;
            int         nb;
            t_rs   = 1'($urandom_range(0, 3) == 0);
            t_poll = 1'($urandom_range(0, 1));
            t_spam = 1'($urandom_range(0, 1));
            nb     = $urandom_range(0, 6);
            r = mk_resp(nb, 8'($urandom) | 8'h80, 8'($urandom) & 8'h7F);
            model(t_rs, t_poll, r, n_rd, m_d, m_b, m_to);
            run_txn($sformatf("rnd%0d", k), t_rs, t_poll, r, t_spam, n_rd, m_d, m_b, m_to);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
